// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through in one cycle and holds loads/stores
// in WAIT until dm_ack. Define MEM_STAGE_TIMEOUT_EN to add the 256-cycle access timeout.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_out,
    input  logic [31:0] pc,
    input  logic [31:0] wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        reg_wr,
    input  logic [1:0]  mem2reg,
    input  logic [4:0]  addrc,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        mem_err,
    output logic        wb_valid,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_mem_out,
    output logic        wb_reg_wr,
    output logic [1:0]  wb_mem2reg,
    output logic [4:0]  wb_addrc
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, next_state;
    logic        start_mem;
    logic        finish_ack;
    logic        finish_tmo;

    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [31:0] hold_pc;
    logic        hold_we;
    logic        hold_reg_wr;
    logic [1:0]  hold_mem2reg;
    logic [4:0]  hold_addrc;

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0]  tmo_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_mem  = 1'b0;
        finish_ack = 1'b0;
        finish_tmo = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && (mem_rd || mem_wr)) begin
                    start_mem  = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // an ack in the timeout cycle still completes normally
                if (dm_ack) begin
                    finish_ack = 1'b1;
                    next_state = S_IDLE;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (tmo_cnt == 8'hFF) begin
                    finish_tmo = 1'b1;
                    next_state = S_IDLE;
                end
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_addr    <= '0;
            hold_wdata   <= '0;
            hold_pc      <= '0;
            hold_we      <= 1'b0;
            hold_reg_wr  <= 1'b0;
            hold_mem2reg <= '0;
            hold_addrc   <= '0;
            wb_valid     <= 1'b0;
            wb_alu_out   <= '0;
            wb_pc        <= '0;
            wb_mem_out   <= '0;
            wb_reg_wr    <= 1'b0;
            wb_mem2reg   <= '0;
            wb_addrc     <= '0;
        end else begin
            // bubble by default; reg_wr follows valid so bubbles never write
            wb_valid  <= 1'b0;
            wb_reg_wr <= 1'b0;
            if (start_mem) begin
                hold_addr    <= alu_out;
                hold_wdata   <= wdata;
                hold_pc      <= pc;
                hold_we      <= mem_wr;
                hold_reg_wr  <= reg_wr;
                hold_mem2reg <= mem2reg;
                hold_addrc   <= addrc;
            end else if (state == S_IDLE && in_valid) begin
                wb_valid   <= 1'b1;
                wb_alu_out <= alu_out;
                wb_pc      <= pc;
                wb_mem_out <= '0;
                wb_reg_wr  <= reg_wr;
                wb_mem2reg <= mem2reg;
                wb_addrc   <= addrc;
            end else if (finish_ack || finish_tmo) begin
                wb_valid   <= 1'b1;
                wb_alu_out <= hold_addr;
                wb_pc      <= hold_pc;
                wb_mem_out <= (finish_ack && !hold_we) ? dm_rdata : 32'h0;
                wb_reg_wr  <= finish_ack ? hold_reg_wr : 1'b0;
                wb_mem2reg <= hold_mem2reg;
                wb_addrc   <= hold_addrc;
            end
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= finish_tmo;
            if (start_mem)
                tmo_cnt <= '0;
            else if (state == S_WAIT && !dm_ack)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

    assign dm_req   = (state == S_WAIT);
    assign stall    = dm_req;
    assign dm_we    = dm_req & hold_we;
    assign dm_addr  = dm_req ? hold_addr  : 32'h0;
    assign dm_wdata = dm_req ? hold_wdata : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, load/store handshakes,
// reset during WAIT, and the timeout path when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_out, pc, wdata;
    logic        mem_rd, mem_wr, reg_wr;
    logic [1:0]  mem2reg;
    logic [4:0]  addrc;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall, mem_err;
    logic        wb_valid, wb_reg_wr;
    logic [31:0] wb_alu_out, wb_pc, wb_mem_out;
    logic [1:0]  wb_mem2reg;
    logic [4:0]  wb_addrc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_out(alu_out), .pc(pc),
        .wdata(wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .mem2reg(mem2reg), .addrc(addrc), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .mem_err(mem_err), .wb_valid(wb_valid), .wb_alu_out(wb_alu_out),
        .wb_pc(wb_pc), .wb_mem_out(wb_mem_out), .wb_reg_wr(wb_reg_wr),
        .wb_mem2reg(wb_mem2reg), .wb_addrc(wb_addrc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] p,
                          input logic [31:0] d, input logic rd, input logic wr,
                          input logic rw, input logic [1:0] m2r, input logic [4:0] rc);
        in_valid = v; alu_out = a; pc = p; wdata = d;
        mem_rd = rd; mem_wr = wr; reg_wr = rw; mem2reg = m2r; addrc = rc;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, ".dm_req"},   32'(dm_req),   32'h0);
        chk({tag, ".stall"},    32'(stall),    32'h0);
        chk({tag, ".dm_addr"},  dm_addr,       32'h0);
        chk({tag, ".dm_we"},    32'(dm_we),    32'h0);
        chk({tag, ".dm_wdata"}, dm_wdata,      32'h0);
    endtask

    initial begin
        // reset with random inputs, including a stray ack
        reset = 1'b0;
        set_op(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 2'd3, 5'd31);
        dm_ack = 1'b1; dm_rdata = $urandom;
        tick();
        set_op(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b1, 1'b1, 2'd2, 5'd17);
        tick();
        chk_idle_bus("rst");
        chk("rst.mem_err",    32'(mem_err),    32'h0);
        chk("rst.wb_valid",   32'(wb_valid),   32'h0);
        chk("rst.wb_alu_out", wb_alu_out,      32'h0);
        chk("rst.wb_pc",      wb_pc,           32'h0);
        chk("rst.wb_mem_out", wb_mem_out,      32'h0);
        chk("rst.wb_reg_wr",  32'(wb_reg_wr),  32'h0);
        chk("rst.wb_mem2reg", 32'(wb_mem2reg), 32'h0);
        chk("rst.wb_addrc",   32'(wb_addrc),   32'h0);

        // ALU op, one-cycle latency
        reset = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
        set_op(1'b1, 32'h10, 32'h40, 32'hAAAA5555, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5);
        tick();
        chk("alu.wb_valid",   32'(wb_valid),  32'h1);
        chk("alu.wb_alu_out", wb_alu_out,     32'h10);
        chk("alu.wb_pc",      wb_pc,          32'h40);
        chk("alu.wb_addrc",   32'(wb_addrc),  32'd5);
        chk("alu.wb_reg_wr",  32'(wb_reg_wr), 32'h1);
        chk("alu.wb_mem_out", wb_mem_out,     32'h0);
        chk_idle_bus("alu");

        // load, ack on third WAIT cycle; inputs during WAIT are junk
        set_op(1'b1, 32'h100, 32'h44, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd8);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 32'hBAD0 + i, 32'hBAD, 32'hBAD, 1'b0, 1'b1, 1'b0, 2'd2, 5'd1);
            if (i == 2) begin dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF; end
            chk("ld.dm_req",   32'(dm_req),    32'h1);
            chk("ld.stall",    32'(stall),     32'h1);
            chk("ld.dm_addr",  dm_addr,        32'h100);
            chk("ld.dm_we",    32'(dm_we),     32'h0);
            chk("ld.wb_valid", 32'(wb_valid),  32'h0);
            chk("ld.wb_reg_wr",32'(wb_reg_wr), 32'h0);
            tick();
        end
        dm_ack = 1'b0; dm_rdata = 32'h0;
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        chk("ld.wb_valid",   32'(wb_valid),   32'h1);
        chk("ld.wb_mem_out", wb_mem_out,      32'hDEADBEEF);
        chk("ld.wb_addrc",   32'(wb_addrc),   32'd8);
        chk("ld.wb_alu_out", wb_alu_out,      32'h100);
        chk("ld.wb_pc",      wb_pc,           32'h44);
        chk("ld.wb_mem2reg", 32'(wb_mem2reg), 32'd1);
        chk("ld.wb_reg_wr",  32'(wb_reg_wr),  32'h1);
        chk_idle_bus("ld.done");

        // ack while idle is ignored
        dm_ack = 1'b1; dm_rdata = 32'h55;
        tick();
        dm_ack = 1'b0;
        chk("idleack.wb_valid", 32'(wb_valid), 32'h0);
        chk("idleack.dm_req",   32'(dm_req),   32'h0);

        // store with rd+wr both set, ack on first WAIT cycle, ALU op behind it
        set_op(1'b1, 32'h200, 32'h48, 32'h12345678, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0);
        tick();
        chk("st.dm_req",   32'(dm_req), 32'h1);
        chk("st.dm_we",    32'(dm_we),  32'h1);
        chk("st.dm_addr",  dm_addr,     32'h200);
        chk("st.dm_wdata", dm_wdata,    32'h12345678);
        chk("st.stall",    32'(stall),  32'h1);
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        set_op(1'b1, 32'h33, 32'h4C, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd3);
        tick();
        dm_ack = 1'b0;
        chk("st.wb_valid",   32'(wb_valid),  32'h1);
        chk("st.wb_mem_out", wb_mem_out,     32'h0);
        chk("st.wb_alu_out", wb_alu_out,     32'h200);
        chk("st.wb_reg_wr",  32'(wb_reg_wr), 32'h0);
        chk_idle_bus("st.done");
        tick();
        chk("nxt.wb_valid",   32'(wb_valid),  32'h1);
        chk("nxt.wb_alu_out", wb_alu_out,     32'h33);
        chk("nxt.wb_addrc",   32'(wb_addrc),  32'd3);
        chk("nxt.wb_reg_wr",  32'(wb_reg_wr), 32'h1);
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0);
        tick();
        chk("bub.wb_valid",  32'(wb_valid),  32'h0);
        chk("bub.wb_reg_wr", 32'(wb_reg_wr), 32'h0);

        // reset on 2nd WAIT cycle, late ack on 3rd
        set_op(1'b1, 32'h300, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd9);
        tick();
        chk("rw.dm_req", 32'(dm_req), 32'h1);
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        tick();
        chk("rw.dm_req1", 32'(dm_req), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_idle_bus("rw.rst");
        chk("rw.wb_valid", 32'(wb_valid), 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        tick();
        dm_ack = 1'b0;
        chk("rw.late.wb_valid", 32'(wb_valid), 32'h0);
        chk("rw.late.wb_mem",   wb_mem_out,    32'h0);
        chk_idle_bus("rw.late");

`ifdef MEM_STAGE_TIMEOUT_EN
        // no ack: WAIT for 256 cycles, then mem_err pulse and a non-writing result
        set_op(1'b1, 32'h400, 32'h60, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd12);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        for (int i = 0; i < 255; i++) tick();
        chk("tmo.pre.stall",   32'(stall),   32'h1);
        chk("tmo.pre.mem_err", 32'(mem_err), 32'h0);
        tick();
        chk("tmo.mem_err",    32'(mem_err),   32'h1);
        chk("tmo.stall",      32'(stall),     32'h0);
        chk("tmo.wb_valid",   32'(wb_valid),  32'h1);
        chk("tmo.wb_reg_wr",  32'(wb_reg_wr), 32'h0);
        chk("tmo.wb_mem_out", wb_mem_out,     32'h0);
        chk("tmo.wb_addrc",   32'(wb_addrc),  32'd12);
        chk("tmo.wb_pc",      wb_pc,          32'h60);
        chk("tmo.wb_alu_out", wb_alu_out,     32'h400);
        tick();
        chk("tmo.post.mem_err", 32'(mem_err), 32'h0);
`else
        chk("noto.mem_err", 32'(mem_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-low reset.
REQ-002 SHALL have inputs: in_valid 1, instruction present; alu_out 32, address or ALU result; pc 32; wdata 32, store data; mem_rd 1; mem_wr 1; reg_wr 1; mem2reg 2; addrc 5.
REQ-003 SHALL have data-memory ports: dm_req out 1; dm_we out 1; dm_addr out 32; dm_wdata out 32; dm_ack in 1, one-cycle completion; dm_rdata in 32, valid with dm_ack.
REQ-004 SHALL have outputs: stall out 1, upstream hold; mem_err out 1, timeout pulse.
REQ-005 SHALL have registered outputs to the writeback stage: wb_valid 1; wb_alu_out 32; wb_pc 32; wb_mem_out 32; wb_reg_wr 1; wb_mem2reg 2; wb_addrc 5.

Function
REQ-006 SHALL use a two-state FSM, IDLE and WAIT.
REQ-007 In IDLE, in_valid=1 with mem_rd=mem_wr=0 SHALL load the wb_* registers from the inputs at the next edge, set wb_valid=1 and wb_mem_out=0, and stay in IDLE (latency 1).
REQ-008 In IDLE, in_valid=1 with mem_rd or mem_wr SHALL latch alu_out, wdata, pc, reg_wr, mem2reg, addrc, and the write flag into holding registers, enter WAIT, and load wb_valid=0.
REQ-009 In IDLE, in_valid=0 SHALL load wb_valid=0 and stay in IDLE.
REQ-010 mem_rd and mem_wr both set SHALL be treated as a store.
REQ-011 dm_req SHALL be 1 exactly while in WAIT.
REQ-012 In WAIT, dm_addr, dm_we and dm_wdata SHALL equal the held address, the held write flag and the held store data, stable until exit.
REQ-013 In IDLE, dm_addr, dm_we and dm_wdata SHALL be 0.
REQ-014 stall SHALL be 1 exactly while in WAIT, including the ack cycle; all stage inputs except dm_ack and dm_rdata are ignored in WAIT.
REQ-015 In WAIT, dm_ack=1 SHALL load the wb_* registers from the held values at the next edge and return to IDLE.
- wb_mem_out SHALL be dm_rdata for a load and 0 for a store.
- wb_valid SHALL be 1.
REQ-016 dm_ack in IDLE SHALL be ignored.
REQ-017 The earliest dm_ack is the first WAIT cycle, so a memory operation completes in at least 2 edges.
REQ-018 wb_reg_wr SHALL be 0 whenever wb_valid is 0, so bubbles never write the register file.
REQ-019 A held instruction SHALL be re-presented by upstream in the first IDLE cycle after WAIT and accepted there, with no loss and no duplication.
REQ-020 All address and data paths SHALL be 32 bits wide, with no alignment checks and no modification of the address.

Reset
REQ-021 reset=0 at a clk edge SHALL force IDLE and clear every output, wb_* register and holding register to 0, including dm_req, stall and mem_err.
REQ-022 reset asserted in WAIT SHALL abandon the access, with dm_req low from the following cycle and no wb_valid pulse for it.
REQ-023 A late dm_ack after reset SHALL be ignored per REQ-016.

Configuration
REQ-024 Macro MEM_STAGE_TIMEOUT_EN SHALL control the timeout feature.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without dm_ack.
- Defined: on the 256th consecutive WAIT cycle without dm_ack, the stage returns to IDLE and pulses mem_err for one cycle.
- Defined: the wb_* registers then load with wb_valid=1, wb_reg_wr=0, wb_mem_out=0, and the held addrc, pc and alu_out.
- Defined: dm_ack in the timeout cycle takes priority and completes normally.
REQ-025 Without the macro, mem_err SHALL be tied to 0, no counter SHALL exist, and WAIT SHALL last until dm_ack.

Verification
REQ-026 Reset: hold reset=0 for 2 cycles with random inputs -> every output 0 and stall=0.
REQ-027 ALU op: in_valid=1, alu_out=0x00000010, addrc=5, reg_wr=1, mem2reg=0 -> next cycle wb_valid=1, wb_alu_out=0x10, wb_addrc=5, wb_reg_wr=1, stall=0, dm_req=0.
REQ-028 Load with ack on 3rd WAIT cycle: alu_out=0x100, mem_rd=1, addrc=8, mem2reg=1, dm_rdata=0xDEADBEEF -> dm_req=1 and dm_addr=0x100 for 3 cycles, stall=1 for 3 cycles, wb_valid=0 meanwhile, then wb_mem_out=0xDEADBEEF, wb_addrc=8, wb_valid=1.
REQ-029 Store with ack on the first WAIT cycle: alu_out=0x200, wdata=0x12345678, mem_wr=1 -> one cycle with dm_we=1 and dm_wdata=0x12345678, then wb_valid=1, wb_mem_out=0; a following ALU op is accepted the next cycle.
REQ-030 Reset mid-WAIT: load pending, reset=0 on the 2nd WAIT cycle, dm_ack on the 3rd -> dm_req=0 after reset, wb_valid stays 0, state IDLE.
REQ-031 With MEM_STAGE_TIMEOUT_EN and no dm_ack -> mem_err pulses exactly 256 cycles after WAIT entry, wb_valid=1 with wb_reg_wr=0, and stall drops.
